// File: rtl/pmod_pkg.sv
// Shared constants for the Pmod input-conditioning and display stages.
// Default debounce window is derived from the system clock and a millisecond budget.
package pmod_pkg;

    localparam int JA_WIDTH                 = 4;
    localparam int CLK_HZ                   = 100_000_000;
    localparam int DEBOUNCE_MS_DEFAULT      = 10;
    localparam int DEBOUNCE_CYCLES_DEFAULT  = (CLK_HZ / 1000) * DEBOUNCE_MS_DEFAULT;

endpackage

// File: rtl/debounce_channel.sv
// One active-low bouncy pin: 2-flop sync, stability counter, registered rise/fall pulses.
// Latency DEBOUNCE_CYCLES+2 edges pin->clean; no backpressure, pulses are one cycle wide.
module debounce_channel
    import pmod_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam int                CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]     TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          act;
    logic          stable;
    logic [CW-1:0] cnt;

    // Sync flops reset to 1 so an idle (high) pin reads as released straight away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= pin;
            sync_q2 <= sync_q1;
        end
    end

    assign act = ~sync_q2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (act == stable) begin
                cnt <= '0;
            end else if (cnt == TERM) begin
                // Pulse lands on the same edge as the level change.
                stable <= act;
                cnt    <= '0;
                rise   <= act;
                fall   <= ~act;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign clean = stable;

endmodule

// File: rtl/ja_debounce.sv
// Conditions the four Pmod JA pins into clean active-high levels with rise/fall pulses.
// Latency DEBOUNCE_CYCLES+2 edges per channel; no backpressure, channels fully independent.
module ja_debounce
    import pmod_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                JA0,
    input  logic                JA1,
    input  logic                JA2,
    input  logic                JA3,
    output logic [JA_WIDTH-1:0] clean,
    output logic [JA_WIDTH-1:0] rise,
    output logic [JA_WIDTH-1:0] fall
);

    logic [JA_WIDTH-1:0] ja;

    assign ja = {JA3, JA2, JA1, JA0};

    for (genvar i = 0; i < JA_WIDTH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .pin   (ja[i]),
            .clean (clean[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_ja_debounce.sv
// Directed and randomized bench for ja_debounce with a 4-cycle debounce window.
module tb_ja_debounce;

    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic [3:0] ja;
    logic [3:0] clean;
    logic [3:0] rise;
    logic [3:0] fall;

    int checks = 0;
    int errors = 0;

    ja_debounce #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .JA0   (ja[0]),
        .JA1   (ja[1]),
        .JA2   (ja[2]),
        .JA3   (ja[3]),
        .clean (clean),
        .rise  (rise),
        .fall  (fall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Reference: counts consecutive cycles where the synchronized active level disagrees.
    logic [3:0] m_s1, m_s2, m_st, m_rise, m_fall;
    int         m_run [4];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_st = 4'h0; m_rise = 4'h0; m_fall = 4'h0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                if (!m_s2[i] != m_st[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == D) begin
                        m_st[i]   = !m_s2[i];
                        m_rise[i] = m_st[i];
                        m_fall[i] = !m_st[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = ja;
        end
    end

    initial begin
        logic [3:0] prev_rise;
        logic [3:0] prev_fall;
        int         lows [3];

        lows[0] = 1; lows[1] = 2; lows[2] = 3;
        rst = 1'b1;
        ja  = 4'hF;
        ticks(3);
        rst = 1'b0;

        for (int k = 0; k < 20; k++) begin
            chk("reset_idle", {clean, rise, fall}, 12'h000);
            tick();
        end

        // Clean press and release on JA0.
        ja[0] = 1'b0;
        ticks(5);
        chk("press_early_clean", clean, 4'h0);
        chk("press_early_rise", rise, 4'h0);
        tick();
        chk("press_clean", clean, 4'h1);
        chk("press_rise", rise, 4'h1);
        tick();
        chk("press_rise_1cyc", rise, 4'h0);
        ticks(4);
        chk("press_hold", {clean, rise, fall}, 12'h100);
        ja[0] = 1'b1;
        ticks(5);
        chk("release_early", {clean, fall}, 8'h10);
        tick();
        chk("release_fall", fall, 4'h1);
        chk("release_clean", clean, 4'h0);
        tick();
        chk("release_fall_1cyc", fall, 4'h0);

        // Bounce train on JA1: runs of 1, 2 and 3 cycles never qualify.
        for (int r = 0; r < 3; r++) begin
            ja[1] = 1'b0;
            for (int k = 0; k < lows[r]; k++) begin
                tick();
                chk("bounce_quiet", {clean, rise, fall}, 12'h000);
            end
            ja[1] = 1'b1;
            for (int k = 0; k < lows[r]; k++) begin
                tick();
                chk("bounce_quiet", {clean, rise, fall}, 12'h000);
            end
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("bounce_settle", {clean, rise, fall}, 12'h000);
        end
        ja[1] = 1'b0;
        ticks(3);
        ja[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("low3_rejected", {clean, rise, fall}, 12'h000);
        end
        ja[1] = 1'b0;
        ticks(4);
        ja[1] = 1'b1;
        tick();
        chk("low4_pre", rise, 4'h0);
        tick();
        chk("low4_rise", rise, 4'h2);
        chk("low4_clean", clean, 4'h2);
        ticks(10);
        chk("low4_back_low", clean, 4'h0);

        // All four pins pressed together, then JA2 released alone.
        ja = 4'h0;
        ticks(5);
        chk("simul_early", rise, 4'h0);
        tick();
        chk("simul_rise", rise, 4'hF);
        chk("simul_clean", clean, 4'hF);
        tick();
        chk("simul_rise_1cyc", rise, 4'h0);
        ja[2] = 1'b1;
        ticks(5);
        chk("rel2_early", fall, 4'h0);
        tick();
        chk("rel2_fall", fall, 4'h4);
        chk("rel2_rise", rise, 4'h0);
        chk("rel2_clean", clean, 4'hB);
        tick();
        chk("rel2_fall_1cyc", fall, 4'h0);

        // Asynchronous reset between edges clears outputs immediately.
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst", {clean, rise, fall}, 12'h000);
        ja = 4'hF;
        tick();
        tick();
        rst = 1'b0;
        ticks(3);

        // Reset in the middle of a count discards the progress.
        ja[3] = 1'b0;
        ticks(3);
        rst = 1'b1;
        tick();
        chk("midrst_held", {clean, rise, fall}, 12'h000);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("midrst_no_early", {clean, rise, fall}, 12'h000);
        end
        tick();
        chk("midrst_rise", rise, 4'h8);
        chk("midrst_clean", clean, 4'h8);

        // Random soak against the reference model.
        prev_rise = rise;
        prev_fall = fall;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 5) == 0) ja[i] = ~ja[i];
            tick();
            chk("soak_model", {clean, rise, fall}, {m_st, m_rise, m_fall});
            chk("soak_excl", rise & fall, 4'h0);
            chk("soak_width", (prev_rise & rise) | (prev_fall & fall), 4'h0);
            prev_rise = rise;
            prev_fall = fall;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ja_debounce.md
# ja_debounce

Input-conditioning stage for the four Pmod JA lines that drive the LED display stage. Each active-low, bouncy JA pin is synchronized into `clk`, inverted to active-high and debounced by a per-channel stability counter. The block produces clean levels plus one-cycle rise and fall pulses. The LED stage and later control logic consume the clean levels instead of the raw pins.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000 (10 ms at 100 MHz): the number of consecutive cycles a synchronized input must differ from the stable state before that state changes. Legal range is 2 or greater.

Ports:
- `clk`  input  1  system clock; one clock domain only.
- `rst`  input  1  asynchronous, active-high reset.
- `JA0`..`JA3`  input  1 each  raw Pmod pins; active-low and asynchronous to `clk`.
- `clean`  output  4  debounced active-high level; bit i corresponds to `JAi`.
- `rise`  output  4  one-cycle pulse when `clean[i]` goes 0→1 (press).
- `fall`  output  4  one-cycle pulse when `clean[i]` goes 1→0 (release).

## Operation
- Each of the four channels is independent and identical.
- **Synchronizer:** two flops per pin; `sync_q2` is the synchronized pin value. The channel uses `act = ~sync_q2`.
- **Per-channel state:** `stable` (1 bit) and `cnt` (width `$clog2(DEBOUNCE_CYCLES)`).
- Each cycle:
  - If `act == stable`: `cnt <= 0`.
  - If `act != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - If `act != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= act`, `cnt <= 0`, and the matching `rise` or `fall` bit is asserted next cycle.
- **Glitch rejection:** any return of `act` to `stable` before the terminal count clears `cnt`. A bounce train whose runs are all shorter than `DEBOUNCE_CYCLES` never changes `clean`.
- **Outputs:** `clean = stable`. `rise`/`fall` are registered and high for exactly one cycle, in the same cycle `clean` first shows the new value. `rise[i]` and `fall[i]` are never high together.
- **Reset values:**
  - Synchronizer flops = 1 (pin idle high, so the released state is correct immediately).
  - `stable` = 0, `cnt` = 0, `clean` = 0, `rise` = 0, `fall` = 0.
- **Reset mid-count:** all counting progress is discarded. No pulse is emitted during reset or on the first cycle after reset.
- **Simultaneous events:** channels may change in the same cycle; each raises its own pulse bit independently.

## Timing
- Let the pin change settle before clock edge E0.
- `sync_q2` reflects the change after edge E2; `act != stable` is first seen in the cycle after E2.
- `cnt` reaches `DEBOUNCE_CYCLES-1` after `DEBOUNCE_CYCLES-1` further edges. `stable` updates on the next edge.
- Total latency from E0 to `clean`/pulse visible is `DEBOUNCE_CYCLES + 2` clock edges.
- The release path has the same latency.
- A pulse lasts exactly one cycle, with no back-to-back repeats while the input is held.
- Minimum spacing between consecutive pulses on one channel is `DEBOUNCE_CYCLES` cycles.
- There is no combinational path from inputs to outputs.

## Structure
- Shared package `pmod_pkg` holds:
  - `JA_WIDTH = 4`
  - `CLK_HZ = 100_000_000`
  - `DEBOUNCE_MS_DEFAULT = 10`, with the derived default cycle constant.
- Sub-module `debounce_channel`:
  - Contents: synchronizer, counter, `stable` and pulse registers for one bit.
  - Instantiated four times by a generate loop in `ja_debounce`.
  - Parameterized by `DEBOUNCE_CYCLES`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`.
- **Reset:** hold `rst` high with JA = 4'b1111, then release. `clean` = 0, `rise` = `fall` = 0 for 20 cycles; assert `rst` asynchronously mid-cycle and check outputs clear without a clock edge.
- **Clean press:** drive JA0 low and hold it. `clean[0]` and `rise[0]` rise exactly 6 edges later; `rise[0]` is high for 1 cycle only. Releasing gives `fall[0]` 6 edges after release.
- **Bounce rejection:** toggle JA1 low/high with runs of 1, 2 and 3 cycles, then hold high. `clean[1]` stays 0 and no pulses occur. Follow with a 3-cycle-low run and a 4-cycle-low run: only the 4-cycle run produces `rise[1]`.
- **Simultaneous:** drive JA0..JA3 low on the same edge. All four `rise` bits pulse together, then `clean` = 4'b1111. Release JA2 only: only `fall[2]` pulses.
- **Reset mid-count:** drive JA3 low, assert `rst` after 3 cycles, release `rst` and keep JA3 low. `rise[3]` occurs a full 6 edges after `rst` release, not earlier.
- **Random soak:** randomized JA stimulus for 10k cycles, compared against a cycle-accurate reference model. The bench also checks that `rise & fall == 0` and that each pulse is exactly 1 cycle wide.
